legv8_multicycle_ctrl: RTL and testbench
========================================

// Module: legv8_multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the LEGv8 core: sequences fetch/decode/execute/memory/writeback
//  over one shared ALU and one instruction/data memory port. Drives alu_op[1:0] to the ALU
//  control decoder and all datapath enables; waits on a memory ready handshake.
//  Counts retired instructions.
// PARAMETERS
//  OPC_W   11   opcode field width (instr[31:21])
//  CNT_W   32   retired-instruction counter width
// PORTS
//  clk         in   1      sole clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  opcode      in   OPC_W  IR[31:21], valid from DECODE onward
//  alu_zero    in   1      ALU zero flag, valid in EXEC
//  mem_ready   in   1      memory has completed current req (1-cycle pulse or level)
//  mem_req     out  1      memory request (fetch or data)
//  mem_we      out  1      write strobe, qualifies mem_req (STUR only)
//  ir_write    out  1      latch instruction register
//  pc_write    out  1      update PC
//  pc_src      out  1      0: PC+4, 1: branch target
//  alu_op      out  2      00 add (addr), 01 pass-B/CBZ, 10 R-type via funct
//  alu_src     out  1      0: register B, 1: sign-extended imm
//  reg2_loc    out  1      1: Rt field as read reg 2 (STUR/CBZ)
//  reg_write   out  1      register file write enable
//  mem_to_reg  out  1      1: writeback data from memory
//  trap        out  1      illegal opcode seen (CTRL_ILLEGAL_TRAP_EN only, else tied 0)
//  retired     out  CNT_W  count of completed instructions
// BEHAVIOUR
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs Moore on state; pc_write in
//   EXEC additionally depends on alu_zero/class.
//  rst=1 at a clock edge: state<=IDLE, retired<=0, trap<=0; in IDLE all outputs 0.
//   Reset mid-transaction abandons it; mem_req drops the cycle after the reset edge.
//  IDLE -> FETCH unconditionally.
//  FETCH: mem_req=1, mem_we=0. Hold until mem_ready; that cycle ir_write=1, pc_write=1,
//   pc_src=0; -> DECODE.
//  DECODE (1 cycle): classify opcode. R: ADD 10001011000, SUB 11001011000,
//   AND 10001010000, ORR 10101010000. LD: 11111000010. ST: 11111000000.
//   CBZ: opcode[10:3]=10110100. B: opcode[10:5]=000101. Class latched internally.
//  EXEC: R: alu_op=10, alu_src=0 -> WB. LD/ST: alu_op=00, alu_src=1, reg2_loc=ST -> MEM.
//   CBZ: alu_op=01, reg2_loc=1; pc_write=alu_zero, pc_src=1 -> FETCH.
//   B: pc_write=1, pc_src=1 -> FETCH.
//  MEM: mem_req=1, mem_we=ST. Hold until mem_ready; then LD -> WB, ST -> FETCH.
//  WB (1 cycle): reg_write=1, mem_to_reg=LD -> FETCH.
//  retired += 1 (wraps at 2^CNT_W) on every exit to FETCH from EXEC, MEM(ST) or WB.
//  mem_ready while mem_req=0 is ignored. mem_ready already high on entry completes
//   in that same cycle (minimum 1-cycle FETCH/MEM).
//  Unused outputs 0 in each state. Latency with ready tied 1: R=4, LD=5, ST=4, CBZ/B=3 cycles.
// CONFIGURATION
//  CTRL_ILLEGAL_TRAP_EN defined: unrecognised opcode in DECODE -> HALT; trap=1,
//   all other outputs 0, held until rst; not counted in retired.
//  Undefined: unrecognised opcode executes as NOP (DECODE -> FETCH, retired += 1),
//   trap tied 0, HALT unreachable.
// TESTING
//  Reset: rst=1 2 cycles -> all outputs 0, retired=0; first cycle after release IDLE, then mem_req=1.
//  ADD 10001011000, mem_ready=1 -> FETCH,DECODE,EXEC(alu_op=10),WB(reg_write=1); retired=1 after 4 cycles.
//  LDUR 11111000010, data mem_ready delayed 3 cycles -> mem_req held 4 MEM cycles, mem_we=0,
//   then WB with mem_to_reg=1.
//  CBZ (opcode 10110100xxx): alu_zero=1 -> pc_write=1, pc_src=1 in EXEC;
//   alu_zero=0 -> pc_write=0; both retire.
//  rst asserted in MEM of STUR -> next cycle IDLE, mem_req=0, mem_we=0, no retire.
//  Opcode 00000000000: with CTRL_ILLEGAL_TRAP_EN -> trap=1 stuck, no mem_req;
//   without -> NOP, retired increments, next FETCH.

Source files
------------

// File: rtl/legv8_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// legv8_multicycle_ctrl
// Multi-cycle control FSM for the LEGv8 core. One instruction at a time walks
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over a single shared ALU and a
// single instruction/data memory port. Memory accesses are held until the
// memory answers with mem_ready. Completed instructions are counted.
//
// Build option:
//   CTRL_ILLEGAL_TRAP_EN  defined   : unrecognised opcode -> HALT with trap=1
//                                     until reset, not counted as retired.
//                         undefined : unrecognised opcode retires as a NOP,
//                                     trap is tied 0.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   opcode      IR[31:21], valid from DECODE onward
//   alu_zero    ALU zero flag, consulted in EXEC for CBZ
//   mem_ready   memory completed the current request (ignored unless mem_req)
//   mem_req     memory request (fetch or data)
//   mem_we      write strobe qualifying mem_req (STUR only)
//   ir_write    latch instruction register
//   pc_write    update PC
//   pc_src      0: PC+4, 1: branch target
//   alu_op      00 add, 01 pass-B (CBZ), 10 R-type via funct
//   alu_src     0: register B, 1: sign-extended immediate
//   reg2_loc    1: Rt field selects read register 2 (STUR/CBZ)
//   reg_write   register file write enable
//   mem_to_reg  1: writeback data comes from memory
//   trap        illegal opcode halt indicator
//   retired     count of completed instructions (wraps)
// -----------------------------------------------------------------------------
module legv8_multicycle_ctrl #(
    parameter int OPC_W = 11,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             reg2_loc,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_LD, C_ST, C_CBZ, C_B, C_ILL
    } iclass_t;

    state_t           state_q, state_d;
    iclass_t          class_q, class_d, decoded;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    // Opcode classification; only meaningful while in DECODE, where it is latched.
    always_comb begin
        decoded = C_ILL;
        if (opcode[10:0] == 11'b10001011000 || opcode[10:0] == 11'b11001011000 ||
            opcode[10:0] == 11'b10001010000 || opcode[10:0] == 11'b10101010000)
            decoded = C_R;
        else if (opcode[10:0] == 11'b11111000010)
            decoded = C_LD;
        else if (opcode[10:0] == 11'b11111000000)
            decoded = C_ST;
        else if (opcode[10:3] == 8'b10110100)
            decoded = C_CBZ;
        else if (opcode[10:5] == 6'b000101)
            decoded = C_B;
    end

    // NOTE: every output and next-state variable gets a default before the case,
    // so no path through this block can leave a value unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_op     = 2'b00;
        alu_src    = 1'b0;
        reg2_loc   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;

        unique case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;          // pc_src stays 0: PC+4
                    state_d  = S_DECODE;
                end
            end

            S_DECODE: begin
                class_d = decoded;
                if (decoded != C_ILL) begin
                    state_d = S_EXEC;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_FETCH;        // NOP: retires without touching state
                    retire  = 1'b1;
`endif
                end
            end

            S_EXEC: begin
                unique case (class_q)
                    C_R: begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                    C_LD, C_ST: begin
                        alu_src  = 1'b1;      // address = Rn + imm
                        reg2_loc = (class_q == C_ST);
                        state_d  = S_MEM;
                    end
                    C_CBZ: begin
                        alu_op   = 2'b01;
                        reg2_loc = 1'b1;
                        pc_write = alu_zero;  // only this output is Mealy
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    C_B: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (class_q == C_ST);
                if (mem_ready) begin
                    if (class_q == C_ST) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (class_q == C_LD);
                retire     = 1'b1;
                state_d    = S_FETCH;
            end

            S_HALT: state_d = S_HALT;         // left only through rst

            default: state_d = S_IDLE;
        endcase

        retired_d = retired_q + CNT_W'(retire);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            class_q   <= C_ILL;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            retired_q <= retired_d;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign trap = (state_q == S_HALT);
`else
    assign trap = 1'b0;
`endif

    assign retired = retired_q;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_legv8_multicycle_ctrl
// Instruction-level bench: each instruction is expanded, from its class and the
// randomly chosen memory wait counts, into the expected cycle-by-cycle control
// outputs, which are compared against the DUT together with a running count of
// retired instructions.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_legv8_multicycle_ctrl;

    typedef enum int {K_R, K_LD, K_ST, K_CBZ, K_B, K_ILL} kind_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg2_loc;
        logic       reg_write;
        logic       mem_to_reg;
        logic       trap;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] opcode = '0;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, ir_write, pc_write, pc_src;
    logic [1:0]  alu_op;
    logic        alu_src, reg2_loc, reg_write, mem_to_reg, trap;
    logic [31:0] retired;

    outs_t       act;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt = '0;

    legv8_multicycle_ctrl #(.OPC_W(11), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_op(alu_op), .alu_src(alu_src), .reg2_loc(reg2_loc),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .trap(trap),
        .retired(retired)
    );

    assign act = {mem_req, mem_we, ir_write, pc_write, pc_src, alu_op,
                  alu_src, reg2_loc, reg_write, mem_to_reg, trap};

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, compare on the falling edge.
    task automatic cyc(input string tag, input outs_t exp, input logic rdy,
                       input logic z, input logic r);
        rst       = r;
        mem_ready = rdy;
        alu_zero  = z;
        @(negedge clk);
        check({tag, " outs"}, 64'(act), 64'(exp));
        check({tag, " retired"}, 64'(retired), 64'(model_cnt));
        @(posedge clk);
        #1;
    endtask

    function automatic kind_t classify(input logic [10:0] op);
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return K_R;
        if (op == 11'b11111000010) return K_LD;
        if (op == 11'b11111000000) return K_ST;
        if (op[10:3] == 8'b10110100) return K_CBZ;
        if (op[10:5] == 6'b000101) return K_B;
        return K_ILL;
    endfunction

    function automatic logic [10:0] gen_op(input kind_t k);
        logic [10:0] r_ops [4];
        logic [10:0] op;
        r_ops = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
        case (k)
            K_R:   op = r_ops[$urandom_range(0, 3)];
            K_LD:  op = 11'b11111000010;
            K_ST:  op = 11'b11111000000;
            K_CBZ: op = {8'b10110100, 3'($urandom)};
            K_B:   op = {6'b000101, 5'($urandom)};
            default: begin
                op = '0;
                for (int i = 0; i < 50; i++) begin
                    op = 11'($urandom);
                    if (classify(op) == K_ILL) break;
                    op = '0;
                end
            end
        endcase
        return op;
    endfunction

    // rst held two cycles starting from a state whose outputs are 'cur', then one IDLE cycle.
    task automatic do_reset(input outs_t cur);
        cyc("rst_edge", cur, 1'($urandom), 1'($urandom), 1'b1);
        model_cnt = '0;
        cyc("rst_hold", '0, 1'($urandom), 1'($urandom), 1'b1);
        cyc("idle", '0, 1'($urandom), 1'($urandom), 1'b0);
    endtask

    // Runs one instruction starting in FETCH; kf/km are wait cycles before mem_ready.
    task automatic run_instr(input kind_t k, input logic [10:0] op, input int kf,
                             input int km, input logic zex, input bit abort);
        outs_t e;
        for (int i = 0; i < kf; i++) begin
            opcode = 11'($urandom);
            e = '0; e.mem_req = 1'b1;
            cyc("fetch_wait", e, 1'b0, 1'($urandom), 1'b0);
        end
        opcode = 11'($urandom);
        e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        cyc("fetch", e, 1'b1, 1'($urandom), 1'b0);

        opcode = op;
        cyc("decode", '0, 1'($urandom), 1'($urandom), 1'b0);
        if (k == K_ILL) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            e = '0; e.trap = 1'b1;
            for (int i = 0; i < 4; i++)
                cyc("halt", e, 1'($urandom), 1'($urandom), 1'b0);
            do_reset(e);
`else
            model_cnt++;
`endif
            return;
        end

        e = '0;
        case (k)
            K_R:   e.alu_op = 2'b10;
            K_LD:  e.alu_src = 1'b1;
            K_ST:  begin e.alu_src = 1'b1; e.reg2_loc = 1'b1; end
            K_CBZ: begin e.alu_op = 2'b01; e.reg2_loc = 1'b1; e.pc_write = zex; e.pc_src = 1'b1; end
            K_B:   begin e.pc_write = 1'b1; e.pc_src = 1'b1; end
            default: ;
        endcase
        cyc("exec", e, 1'($urandom), zex, 1'b0);
        if (k == K_CBZ || k == K_B) begin
            model_cnt++;
            return;
        end

        if (k == K_LD || k == K_ST) begin
            e = '0; e.mem_req = 1'b1; e.mem_we = (k == K_ST);
            for (int i = 0; i < km; i++)
                cyc("mem_wait", e, 1'b0, 1'($urandom), 1'b0);
            if (abort) begin
                cyc("mem_rst", e, 1'b1, 1'($urandom), 1'b1);
                model_cnt = '0;
                cyc("idle_after_rst", '0, 1'($urandom), 1'($urandom), 1'b0);
                return;
            end
            cyc("mem", e, 1'b1, 1'($urandom), 1'b0);
            if (k == K_ST) begin
                model_cnt++;
                return;
            end
        end

        e = '0; e.reg_write = 1'b1; e.mem_to_reg = (k == K_LD);
        cyc("wb", e, 1'($urandom), 1'($urandom), 1'b0);
        model_cnt++;
    endtask

    initial begin
        kind_t k;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset", '0, 1'b1, 1'b0, 1'b1);
        cyc("reset", '0, 1'b0, 1'b0, 1'b1);
        cyc("idle", '0, 1'b1, 1'b0, 1'b0);

        // Directed cases from the block's documented scenarios.
        run_instr(K_R,   11'b10001011000, 0, 0, 1'b0, 1'b0);
        run_instr(K_LD,  11'b11111000010, 0, 3, 1'b0, 1'b0);
        run_instr(K_CBZ, 11'b10110100101, 1, 0, 1'b1, 1'b0);
        run_instr(K_CBZ, 11'b10110100010, 0, 0, 1'b0, 1'b0);
        run_instr(K_B,   11'b00010110011, 2, 0, 1'b1, 1'b0);
        run_instr(K_ST,  11'b11111000000, 0, 2, 1'b0, 1'b0);
        run_instr(K_R,   11'b10101010000, 0, 0, 1'b0, 1'b0);
        run_instr(K_ST,  11'b11111000000, 1, 1, 1'b0, 1'b1);
        run_instr(K_ILL, 11'b00000000000, 0, 0, 1'b0, 1'b0);

        // Randomized instruction stream.
        for (int n = 0; n < 200; n++) begin
            k = kind_t'($urandom_range(0, 5));
            run_instr(k, gen_op(k), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), (k == K_ST) && ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
